// File: rtl/spi_keys_host.sv
// spi_keys_host: mode-0 SPI master that repeatedly reads a keyboard slave into an atomically updated key snapshot
module spi_keys_host #(
  parameter int NUM_KEYS = 68,
  parameter int CLK_DIV  = 4,
  parameter int BYTE_GAP = 8,
  parameter int SCAN_GAP = 16
) (
  input  logic                clk_g_i,
  input  logic                rstn_g_i,
  input  logic                scan_en_i,
  output logic                spi_clk_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  output logic                spi_cs_o,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic                keys_valid_o,
  output logic                keys_changed_o,
  output logic                busy_o
);
  localparam int GROUPS = (NUM_KEYS + 7) / 8;
  localparam int BW = $clog2(GROUPS + 1);
  localparam int MAX_AB = CLK_DIV > BYTE_GAP ? CLK_DIV : BYTE_GAP;
  localparam int MAXC = MAX_AB > SCAN_GAP ? MAX_AB : SCAN_GAP;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_BYTE_GAP, S_CS_HOLD, S_UPDATE, S_SCAN_WAIT
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d, tx;
  logic [NUM_KEYS-1:0] shd_q, shd_d, keys_q, keys_d;
  logic sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;
  logic valid_q, valid_d, chg_q, chg_d, busy_q, busy_d;
  logic rise;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    byte_d = byte_q;
    bit_d = bit_q;
    sr_d = sr_q;
    shd_d = shd_q;
    keys_d = keys_q;
    sck_d = sck_q;
    cs_d = cs_q;
    valid_d = 1'b0;
    chg_d = 1'b0;
    rise = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (scan_en_i) begin
          state_d = S_CS_SETUP;
          cs_d = 1'b0;
          byte_d = '0;
          bit_d = 3'd7;
        end
      end
      S_CS_SETUP: rise = cnt_q == CW'(CLK_DIV - 1);
      S_BYTE_GAP: rise = cnt_q == CW'(BYTE_GAP - 1);
      S_SHIFT: begin
        rise = !sck_q && cnt_q == CW'(CLK_DIV - 1);
        if (sck_q && cnt_q == CW'(CLK_DIV - 1)) begin
          sck_d = 1'b0;
          cnt_d = '0;
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            for (int k = 0; k < NUM_KEYS; k++)
              if (int'(byte_q) == k / 8 + 1) shd_d[k] = sr_q[k[2:0]];
            if (byte_q == BW'(GROUPS)) begin
              state_d = S_CS_HOLD;
            end else begin
              state_d = S_BYTE_GAP;
              byte_d = byte_q + BW'(1);
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cs_d = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        keys_d = shd_q;
        valid_d = 1'b1;
        chg_d = shd_q != keys_q;
        cnt_d = '0;
        state_d = S_SCAN_WAIT;
      end
      S_SCAN_WAIT: begin
        if (cnt_q == CW'(SCAN_GAP - 2)) begin
          cnt_d = '0;
          byte_d = '0;
          bit_d = 3'd7;
          cs_d = !scan_en_i;
          if (scan_en_i) state_d = S_CS_SETUP;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rise) begin
      state_d = S_SHIFT;
      sck_d = 1'b1;
      cnt_d = '0;
      sr_d = {sr_q[6:0], spi_miso_i};
    end
    tx = byte_d < BW'(GROUPS) ? 8'(byte_d) : 8'h00;
    mosi_d = (state_d inside {S_CS_SETUP, S_SHIFT, S_BYTE_GAP}) && tx[bit_d];
    busy_d = state_d inside {S_CS_SETUP, S_SHIFT, S_BYTE_GAP, S_CS_HOLD};
  end
  always_ff @(posedge clk_g_i) begin
    if (!rstn_g_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      shd_q <= '0;
      keys_q <= '0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_q <= 1'b1;
      valid_q <= 1'b0;
      chg_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      shd_q <= shd_d;
      keys_q <= keys_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      cs_q <= cs_d;
      valid_q <= valid_d;
      chg_q <= chg_d;
      busy_q <= busy_d;
    end
  end
  assign spi_clk_o = sck_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_o = cs_q;
  assign keys_o = keys_q;
  assign keys_valid_o = valid_q;
  assign keys_changed_o = chg_q;
  assign busy_o = busy_q;
endmodule
